// File: rtl/sudoku_button_pkg.sv
// rtl/sudoku_button_pkg.sv - button codes, button count and arbitration priority
package sudoku_button_pkg;

  localparam int NUM_BUTTONS     = 7;
  localparam int NUM_DIRECTIONAL = 4;

  typedef enum logic [2:0] {
    BTN_UP    = 3'd0,
    BTN_DOWN  = 3'd1,
    BTN_LEFT  = 3'd2,
    BTN_RIGHT = 3'd3,
    BTN_START = 3'd4,
    BTN_A     = 3'd5,
    BTN_B     = 3'd6
  } btn_code_t;

  // Highest priority first; the directional codes double as the repeat-capable set.
  localparam btn_code_t PRIORITY_ORDER [NUM_BUTTONS] = '{
    BTN_START, BTN_A, BTN_B, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT
  };

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - one button: 2-flop sync, debounce counter, level and press pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_accept;

  assign w_differs = (r_sync2 != r_level);
  // The edge that would take the count to DEBOUNCE_CYCLES flips the level instead.
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - debounced buttons to prioritised valid/ready command events
// Optional directional auto-repeat is built when AUTO_REPEAT_EN is defined.
module button_event_scheduler
  import sudoku_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   up_button,
  input  logic                   down_button,
  input  logic                   left_button,
  input  logic                   right_button,
  input  logic                   start_button,
  input  logic                   a_button,
  input  logic                   b_button,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [2:0]             cmd_code,
  output logic [NUM_BUTTONS-1:0] held_mask,
  output logic                   overflow
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_event_scheduler: timing parameters out of range");
  end

  logic [NUM_BUTTONS-1:0] w_raw;
  logic [NUM_BUTTONS-1:0] w_level;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [NUM_BUTTONS-1:0] w_event;

  assign w_raw = {b_button, a_button, start_button, right_button,
                  left_button, down_button, up_button};

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (w_raw[g]),
      .o_level (w_level[g]),
      .o_press (w_press[g])
    );
  end

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_V  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD_V = REP_W'(REPEAT_PERIOD);

  // Count value k means k cycles since the press (phase 0) or since the last repeat (phase 1).
  logic [REP_W-1:0]           r_rep_cnt [NUM_DIRECTIONAL];
  logic [NUM_DIRECTIONAL-1:0] r_rep_phase;
  logic [NUM_DIRECTIONAL-1:0] w_rep_fire;

  always_comb begin
    w_rep_fire = '0;
    for (int i = 0; i < NUM_DIRECTIONAL; i++) begin
      w_rep_fire[i] = w_level[i] &&
                      (r_rep_cnt[i] == (r_rep_phase[i] ? REP_PERIOD_V : REP_DELAY_V));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIRECTIONAL; i++) begin
        r_rep_cnt[i] <= '0;
      end
      r_rep_phase <= '0;
    end else begin
      for (int i = 0; i < NUM_DIRECTIONAL; i++) begin
        if (!w_level[i]) begin
          r_rep_cnt[i]   <= '0;
          r_rep_phase[i] <= 1'b0;
        end else if (w_press[i]) begin
          r_rep_cnt[i]   <= REP_W'(1);
          r_rep_phase[i] <= 1'b0;
        end else if (w_rep_fire[i]) begin
          r_rep_cnt[i]   <= REP_W'(1);
          r_rep_phase[i] <= 1'b1;
        end else if (r_rep_cnt[i] != '0) begin
          r_rep_cnt[i] <= r_rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end

  assign w_event = w_press | {{(NUM_BUTTONS - NUM_DIRECTIONAL){1'b0}}, w_rep_fire};
`else
  assign w_event = w_press;
`endif

  logic [NUM_BUTTONS-1:0] r_pending;
  logic [NUM_BUTTONS-1:0] w_grant;
  logic [NUM_BUTTONS-1:0] w_drop;
  logic                   w_load;
  logic                   w_any;
  btn_code_t              w_sel;
  logic                   r_cmd_valid;
  logic [2:0]             r_cmd_code;
  logic                   r_overflow;

  assign w_load = !r_cmd_valid || cmd_ready;

  // Walk lowest to highest priority so the last match is the winner.
  always_comb begin
    w_grant = '0;
    w_sel   = BTN_UP;
    w_any   = 1'b0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (r_pending[PRIORITY_ORDER[i]]) begin
        w_sel = PRIORITY_ORDER[i];
        w_any = 1'b1;
      end
    end
    if (w_load && w_any) begin
      w_grant[w_sel] = 1'b1;
    end
  end

  assign w_drop = w_event & r_pending & ~w_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= 3'd0;
      r_overflow  <= 1'b0;
    end else begin
      r_pending  <= (r_pending & ~w_grant) | w_event;
      r_overflow <= |w_drop;
      if (w_load) begin
        r_cmd_valid <= w_any;
        if (w_any) begin
          r_cmd_code <= w_sel;
        end
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign held_mask = w_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_button_event_scheduler.sv
// tb/tb_button_event_scheduler.sv - scenario tasks plus random run against a behavioural model
module tb_button_event_scheduler;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] raw = '0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [6:0] held_mask;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_event_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .up_button    (raw[0]),
    .down_button  (raw[1]),
    .left_button  (raw[2]),
    .right_button (raw[3]),
    .start_button (raw[4]),
    .a_button     (raw[5]),
    .b_button     (raw[6]),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_code     (cmd_code),
    .held_mask    (held_mask),
    .overflow     (overflow)
  );

`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  // Reference model: spec rules expressed per button, repeats derived from time since press.
  int         prio [7] = '{4, 5, 6, 0, 1, 2, 3};
  logic [6:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_pend = '0;
  int         m_run [7];
  int         m_press_cyc [7];
  int         m_cyc = 0;
  logic       m_valid = 1'b0;
  logic [2:0] m_code = 3'd0;
  logic       m_ovf = 1'b0;

  always @(posedge clk) begin : model
    logic [6:0] ev, grant, press_n;
    int k;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_pend = '0;
      m_valid = 1'b0; m_code = 3'd0; m_ovf = 1'b0;
      for (int b = 0; b < 7; b++) m_run[b] = 0;
    end else begin
      ev = m_press;
      for (int b = 0; b < 4; b++) begin
        if (REP_EN && m_lvl[b] && !m_press[b]) begin
          k = m_cyc - m_press_cyc[b];
          if (k >= RD && ((k - RD) % RP) == 0) ev[b] = 1'b1;
        end
      end
      for (int b = 0; b < 7; b++) if (m_press[b]) m_press_cyc[b] = m_cyc;
      grant = '0;
      if (!m_valid || cmd_ready) begin
        m_valid = 1'b0;
        for (int p = 0; p < 7; p++) begin
          if (!m_valid && m_pend[prio[p]]) begin
            m_valid = 1'b1;
            m_code = 3'(prio[p]);
            grant[prio[p]] = 1'b1;
          end
        end
      end
      m_ovf  = |(ev & m_pend & ~grant);
      m_pend = (m_pend & ~grant) | ev;
      press_n = '0;
      for (int b = 0; b < 7; b++) begin
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_run[b] = 0;
            m_lvl[b] = m_s2[b];
            press_n[b] = m_s2[b];
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_press = press_n;
      m_s2 = m_s1;
      m_s1 = raw;
    end
    m_cyc++;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cmd_valid, cmd_code, held_mask, overflow} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b c=%0d h=%b o=%b, want all zero",
               cmd_valid, cmd_code, held_mask, overflow);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_valid, cmd_code, held_mask, overflow} !== {m_valid, m_code, m_lvl, m_ovf}) begin
        n_fail++;
        $display("FAIL reset_idle: got v=%b c=%0d h=%b o=%b, want v=%b c=%0d h=%b o=%b",
                 cmd_valid, cmd_code, held_mask, overflow, m_valid, m_code, m_lvl, m_ovf);
      end
    end
  endtask

  task automatic test_single_press();
    int first = 0, nvalid = 0;
    cmd_ready = 1'b1;
    raw[5] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_valid, cmd_code, held_mask, overflow} !== {m_valid, m_code, m_lvl, m_ovf}) begin
        n_fail++;
        $display("FAIL single_press_model edge %0d: got v=%b c=%0d h=%b o=%b, want v=%b c=%0d h=%b o=%b",
                 i, cmd_valid, cmd_code, held_mask, overflow, m_valid, m_code, m_lvl, m_ovf);
      end
      if (cmd_valid) begin
        nvalid++;
        if (first == 0) first = i;
        n_tests++;
        if (cmd_code !== 3'd5) begin
          n_fail++;
          $display("FAIL single_press_code: got %0d, want 5", cmd_code);
        end
      end
      if (i == 10) raw[5] = 1'b0;
    end
    n_tests++;
    if (first != D + 4) begin
      n_fail++;
      $display("FAIL single_press_latency: got %0d edges, want %0d", first, D + 4);
    end
    n_tests++;
    if (nvalid != 1) begin
      n_fail++;
      $display("FAIL single_press_count: got %0d valid cycles, want 1", nvalid);
    end
  endtask

  task automatic test_bounce();
    int nvalid = 0;
    logic [6:0] held_or = '0;
    cmd_ready = 1'b1;
    raw[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_valid, cmd_code, held_mask, overflow} !== {m_valid, m_code, m_lvl, m_ovf}) begin
        n_fail++;
        $display("FAIL bounce_model edge %0d: got v=%b c=%0d h=%b o=%b, want v=%b c=%0d h=%b o=%b",
                 i, cmd_valid, cmd_code, held_mask, overflow, m_valid, m_code, m_lvl, m_ovf);
      end
      if (cmd_valid) nvalid++;
      held_or |= held_mask;
      raw[0] = (i < 12) ? ~raw[0] : 1'b0;
    end
    n_tests++;
    if (nvalid != 0 || held_or !== 7'd0) begin
      n_fail++;
      $display("FAIL bounce_reject: got %0d valid, held %b, want 0 valid, held 0", nvalid, held_or);
    end
  endtask

  task automatic test_priority_backpressure();
    int got[$];
    cmd_ready = 1'b0;
    raw[4] = 1'b1; raw[0] = 1'b1; raw[6] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_valid, cmd_code, held_mask, overflow} !== {m_valid, m_code, m_lvl, m_ovf}) begin
        n_fail++;
        $display("FAIL prio_model edge %0d: got v=%b c=%0d h=%b o=%b, want v=%b c=%0d h=%b o=%b",
                 i, cmd_valid, cmd_code, held_mask, overflow, m_valid, m_code, m_lvl, m_ovf);
      end
      if (cmd_valid) begin
        n_tests++;
        if (cmd_code !== 3'd4) begin
          n_fail++;
          $display("FAIL prio_stall_hold: got %0d, want 4", cmd_code);
        end
      end
      if (i == 10) raw = '0;
    end
    cmd_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      if (cmd_valid) got.push_back(int'(cmd_code));
      @(negedge clk);
      n_tests++;
      if ({cmd_valid, cmd_code, held_mask, overflow} !== {m_valid, m_code, m_lvl, m_ovf}) begin
        n_fail++;
        $display("FAIL prio_drain_model: got v=%b c=%0d, want v=%b c=%0d",
                 cmd_valid, cmd_code, m_valid, m_code);
      end
    end
    n_tests++;
    if (got.size() != 3 || got[0] != 4 || got[1] != 6 || got[2] != 0) begin
      n_fail++;
      $display("FAIL prio_order: got %p, want '{4, 6, 0}", got);
    end
  endtask

  task automatic test_overflow();
    int got[$];
    int novf = 0;
    cmd_ready = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      raw[4] = (i <= 10);
      raw[2] = (i > 12 && i <= 22) || (i > 32 && i <= 42);
      @(negedge clk);
      n_tests++;
      if ({cmd_valid, cmd_code, held_mask, overflow} !== {m_valid, m_code, m_lvl, m_ovf}) begin
        n_fail++;
        $display("FAIL ovf_model edge %0d: got v=%b c=%0d h=%b o=%b, want v=%b c=%0d h=%b o=%b",
                 i, cmd_valid, cmd_code, held_mask, overflow, m_valid, m_code, m_lvl, m_ovf);
      end
      if (overflow) novf++;
    end
    raw = '0;
    n_tests++;
    if (novf != 1) begin
      n_fail++;
      $display("FAIL ovf_pulses: got %0d, want 1", novf);
    end
    cmd_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (cmd_valid) got.push_back(int'(cmd_code));
      @(negedge clk);
    end
    n_tests++;
    if (got.size() != 2 || got[0] != 4 || got[1] != 2) begin
      n_fail++;
      $display("FAIL ovf_delivered: got %p, want '{4, 2}", got);
    end
  endtask

  task automatic test_auto_repeat();
    int seen[$];
    int expv[$];
    expv.push_back(0);
    if (REP_EN) for (int k = RD; k < 60; k += RP) expv.push_back(k);
    cmd_ready = 1'b1;
    raw[3] = 1'b1;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_valid, cmd_code, held_mask, overflow} !== {m_valid, m_code, m_lvl, m_ovf}) begin
        n_fail++;
        $display("FAIL repeat_model edge %0d: got v=%b c=%0d h=%b o=%b, want v=%b c=%0d h=%b o=%b",
                 i, cmd_valid, cmd_code, held_mask, overflow, m_valid, m_code, m_lvl, m_ovf);
      end
      if (cmd_valid && cmd_code == 3'd3) seen.push_back(i);
      if (i == 60) raw[3] = 1'b0;
    end
    for (int j = seen.size() - 1; j >= 0; j--) seen[j] = seen[j] - seen[0];
    n_tests++;
    if (seen != expv) begin
      n_fail++;
      $display("FAIL repeat_offsets: got %p, want %p", seen, expv);
    end
  endtask

  task automatic test_reset_mid();
    int first = 0, nvalid = 0;
    cmd_ready = 1'b0;
    raw[5] = 1'b1;
    repeat (12) @(negedge clk);
    raw[4] = 1'b1;
    repeat (12) @(negedge clk);
    n_tests++;
    if (!(cmd_valid && cmd_code == 3'd5)) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got v=%b c=%0d, want v=1 c=5", cmd_valid, cmd_code);
    end
    reset = 1'b1; raw[5] = 1'b0; raw[4] = 1'b0; raw[1] = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({cmd_valid, cmd_code, held_mask, overflow} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got v=%b c=%0d h=%b o=%b, want all zero",
               cmd_valid, cmd_code, held_mask, overflow);
    end
    reset = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_tests++;
      if ({cmd_valid, cmd_code, held_mask, overflow} !== {m_valid, m_code, m_lvl, m_ovf}) begin
        n_fail++;
        $display("FAIL reset_mid_model edge %0d: got v=%b c=%0d h=%b o=%b, want v=%b c=%0d h=%b o=%b",
                 i, cmd_valid, cmd_code, held_mask, overflow, m_valid, m_code, m_lvl, m_ovf);
      end
      if (cmd_valid) begin
        nvalid++;
        if (first == 0) first = i;
        n_tests++;
        if (cmd_code !== 3'd1) begin
          n_fail++;
          $display("FAIL reset_mid_code: got %0d, want 1", cmd_code);
        end
      end
      if (i == 12) raw[1] = 1'b0;
    end
    n_tests++;
    if (first != D + 4 || nvalid != 1) begin
      n_fail++;
      $display("FAIL reset_mid_latency: got edge %0d count %0d, want edge %0d count 1",
               first, nvalid, D + 4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 7; b++) if ($urandom_range(0, 11) == 0) raw[b] = ~raw[b];
      cmd_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      n_tests++;
      if ({cmd_valid, cmd_code, held_mask, overflow} !== {m_valid, m_code, m_lvl, m_ovf}) begin
        n_fail++;
        $display("FAIL random_model cyc %0d: got v=%b c=%0d h=%b o=%b, want v=%b c=%0d h=%b o=%b",
                 i, cmd_valid, cmd_code, held_mask, overflow, m_valid, m_code, m_lvl, m_ovf);
      end
    end
    reset = 1'b0;
    raw = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_press();
    test_bounce();
    test_priority_backpressure();
    test_overflow();
    test_auto_repeat();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
